// File: rtl/bitmap_allocator_pkg.sv
// Shared widths, FSM encoding and helpers for the MMU slot allocator.
// Imported by bitmap_allocator and its first_zero finder.
package bitmap_allocator_pkg;

  localparam int MAP_W  = 64;
  localparam int SLOT_W = 6;
  localparam int CNT_W  = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    S_MASK = 2'd1,
    S_POS  = 2'd2
  } state_t;

  // Number of clear bits in a map; used for the reset free count.
  function automatic logic [CNT_W-1:0] zero_count(
    input logic [MAP_W-1:0] m
  );
    logic [CNT_W-1:0] c;
    c = CNT_W'(MAP_W);
    for (int i = 0; i < MAP_W; i++)
      if (m[i]) c = c - 1'b1;
    return c;
  endfunction

  // One-hot to 1-based index; 0 when no bit is set.
  function automatic logic [CNT_W-1:0] onehot_pos(
    input logic [MAP_W-1:0] m
  );
    logic [CNT_W-1:0] p;
    p = '0;
    for (int i = 0; i < MAP_W; i++)
      if (m[i]) p = CNT_W'(i + 1);
    return p;
  endfunction

endpackage

// File: rtl/bitmap_allocator_first_zero.sv
// first_zero: pipelined lowest-clear-bit finder.
// Ports: data_in sampled each edge; mask_out/find_success +1 cycle,
// pos_out (1-based, 0 = none) +2 cycles. rst_n async active-low.
module first_zero
  import bitmap_allocator_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [MAP_W-1:0] data_in,
  output logic [MAP_W-1:0] mask_out,
  output logic             find_success,
  output logic [CNT_W-1:0] pos_out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_out     <= '0;
      find_success <= 1'b0;
      pos_out      <= '0;
    end else begin
      // ~d & (d+1) isolates the lowest zero bit.
      mask_out     <= ~data_in & (data_in + 1'b1);
      find_success <= ~&data_in;
      pos_out      <= onehot_pos(mask_out);
    end
  end

endmodule

// File: rtl/bitmap_allocator.sv
// bitmap_allocator: 64-slot occupancy map, lowest-free allocation
// with fixed 3-cycle latency, single-cycle frees and free counter.
// Ports: alloc_req/ready/valid/fail/pos, free_valid/pos/err,
// bitmap_out (current map), free_count (clear bits, 0..64).
module bitmap_allocator
  import bitmap_allocator_pkg::*;
#(
  parameter logic [MAP_W-1:0] INIT_BITMAP = '0
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req,
  output logic              alloc_ready,
  output logic              alloc_valid,
  output logic              alloc_fail,
  output logic [SLOT_W-1:0] alloc_pos,
  input  logic              free_valid,
  input  logic [SLOT_W-1:0] free_pos,
  output logic              free_err,
  output logic [MAP_W-1:0]  bitmap_out,
  output logic [CNT_W-1:0]  free_count
);

  localparam logic [CNT_W-1:0] CNT_INIT = zero_count(INIT_BITMAP);

  state_t             state;
  state_t             state_nx;
  logic               commit;
  logic [MAP_W-1:0]   mask_lat;
  logic               succ_lat;
  logic [MAP_W-1:0]   fz_mask;
  logic               fz_succ;
  logic [CNT_W-1:0]   fz_pos;
  logic [CNT_W-1:0]   pos_m1;
  logic               commit_ok;
  logic               free_hit;
  logic [MAP_W-1:0]   commit_mask;
  logic [MAP_W-1:0]   free_mask;
  logic [MAP_W-1:0]   bitmap_nx;
  logic [CNT_W-1:0]   count_nx;

  first_zero u_fz (
    .clk          (clk),
    .rst_n        (~rst),
    .data_in      (bitmap_out),
    .mask_out     (fz_mask),
    .find_success (fz_succ),
    .pos_out      (fz_pos)
  );

  always_comb begin
    state_nx    = state;
    alloc_ready = 1'b0;
    commit      = 1'b0;
    unique case (state)
      IDLE: begin
        alloc_ready = 1'b1;
        if (alloc_req) state_nx = S_MASK;
      end
      S_MASK: state_nx = S_POS;
      S_POS: begin
        commit   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign commit_ok   = commit & succ_lat;
  assign commit_mask = commit_ok ? mask_lat : '0;
  // Only a set bit can be freed; the commit slot is always clear,
  // so a free aimed at it falls to the error path and commit wins.
  assign free_hit    = free_valid & bitmap_out[free_pos];
  assign free_mask   = free_hit ? (MAP_W'(1) << free_pos) : '0;
  assign bitmap_nx   = (bitmap_out | commit_mask) & ~free_mask;
  assign pos_m1      = fz_pos - 1'b1;

  always_comb begin
    count_nx = free_count;
    unique case ({commit_ok, free_hit})
      2'b10:   count_nx = free_count - 1'b1;
      2'b01:   count_nx = free_count + 1'b1;
      default: count_nx = free_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bitmap_out  <= INIT_BITMAP;
      free_count  <= CNT_INIT;
      mask_lat    <= '0;
      succ_lat    <= 1'b0;
      alloc_valid <= 1'b0;
      alloc_fail  <= 1'b0;
      alloc_pos   <= '0;
      free_err    <= 1'b0;
    end else begin
      state       <= state_nx;
      bitmap_out  <= bitmap_nx;
      free_count  <= count_nx;
      alloc_valid <= commit;
      free_err    <= free_valid & ~bitmap_out[free_pos];
      if (state == S_MASK) begin
        mask_lat <= fz_mask;
        succ_lat <= fz_succ;
      end
      if (commit) begin
        alloc_fail <= ~succ_lat;
        alloc_pos  <= succ_lat ? pos_m1[SLOT_W-1:0] : '0;
      end
    end
  end

endmodule

// File: tb/tb_bitmap_allocator.sv
// Scoreboard bench for bitmap_allocator: directed allocs/frees,
// expected responses queued at issue and checked by a monitor.
module tb_bitmap_allocator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alloc_req = 1'b0;
  logic        alloc_ready;
  logic        alloc_valid;
  logic        alloc_fail;
  logic [5:0]  alloc_pos;
  logic        free_valid = 1'b0;
  logic [5:0]  free_pos = '0;
  logic        free_err;
  logic [63:0] bitmap_out;
  logic [6:0]  free_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic        fail;
    logic [5:0]  pos;
    logic [63:0] map;
    logic [6:0]  cnt;
    int          at;
  } exp_t;

  exp_t aq[$];
  int   fq[$];

  bitmap_allocator #(.INIT_BITMAP(64'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_req   (alloc_req),
    .alloc_ready (alloc_ready),
    .alloc_valid (alloc_valid),
    .alloc_fail  (alloc_fail),
    .alloc_pos   (alloc_pos),
    .free_valid  (free_valid),
    .free_pos    (free_pos),
    .free_err    (free_err),
    .bitmap_out  (bitmap_out),
    .free_count  (free_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (alloc_valid) begin
      if (aq.size() == 0) begin
        check("unexpected_alloc_valid", 1, 0);
      end else begin
        exp_t e;
        e = aq.pop_front();
        check("alloc_latency", cyc, e.at);
        check("alloc_fail", alloc_fail, e.fail);
        check("alloc_pos", alloc_pos, e.pos);
        check("alloc_bitmap", bitmap_out, e.map);
        check("alloc_count", free_count, e.cnt);
      end
    end
    if (free_err) begin
      if (fq.size() == 0) begin
        check("unexpected_free_err", 1, 0);
      end else begin
        int at;
        at = fq.pop_front();
        check("free_err_cycle", cyc, at);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!alloc_ready && k < 8) begin
      tick();
      k++;
    end
    check("ready_wait", alloc_ready, 1);
  endtask

  task automatic do_alloc(input logic f, input logic [5:0] p,
                          input logic [63:0] m, input logic [6:0] c);
    wait_ready();
    aq.push_back('{f, p, m, c, cyc + 3});
    alloc_req = 1'b1;
    tick();
    alloc_req = 1'b0;
  endtask

  task automatic do_reset();
    repeat (4) tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic fill(input int n);
    logic [63:0] m = '0;
    for (int i = 0; i < n; i++) begin
      m[i] = 1'b1;
      do_alloc(1'b0, 6'(i), m, 7'(63 - i));
    end
    repeat (4) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] m;
    tick();
    do_reset();
    check("rst_ready", alloc_ready, 1);
    check("rst_valid", alloc_valid, 0);
    check("rst_fail", alloc_fail, 0);
    check("rst_pos", alloc_pos, 0);
    check("rst_free_err", free_err, 0);
    check("rst_bitmap", bitmap_out, 64'h0);
    check("rst_count", free_count, 64);

    // 64 back-to-back allocs then one on a full map
    m = '0;
    for (int i = 0; i < 64; i++) begin
      m[i] = 1'b1;
      do_alloc(1'b0, 6'(i), m, 7'(63 - i));
    end
    do_alloc(1'b1, 6'd0, {64{1'b1}}, 7'd0);
    repeat (4) tick();
    check("full_bitmap", bitmap_out, {64{1'b1}});

    // free slot 5 of 0xFF, then realloc it
    do_reset();
    fill(8);
    free_valid = 1'b1;
    free_pos   = 6'd5;
    tick();
    free_valid = 1'b0;
    check("free5_bitmap", bitmap_out, 64'hDF);
    check("free5_count", free_count, 57);
    do_alloc(1'b0, 6'd5, 64'hFF, 7'd56);

    // double free of slot 9 on 0x0F
    do_reset();
    fill(4);
    fq.push_back(cyc + 1);
    free_valid = 1'b1;
    free_pos   = 6'd9;
    tick();
    free_valid = 1'b0;
    tick();
    check("dfree_bitmap", bitmap_out, 64'h0F);
    check("dfree_count", free_count, 60);

    // commit of slot 3 with same-edge free of slot 1
    do_reset();
    fill(3);
    do_alloc(1'b0, 6'd3, 64'hD, 7'd61);
    tick();
    free_valid = 1'b1;
    free_pos   = 6'd1;
    tick();
    free_valid = 1'b0;
    repeat (3) tick();

    // free aimed at the slot being committed: error, commit wins
    do_alloc(1'b0, 6'd1, 64'hF, 7'd60);
    tick();
    fq.push_back(cyc + 1);
    free_valid = 1'b1;
    free_pos   = 6'd1;
    tick();
    free_valid = 1'b0;
    repeat (3) tick();

    // reset while the allocate is in S_POS
    do_reset();
    fill(2);
    wait_ready();
    alloc_req = 1'b1;
    tick();
    alloc_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ready", alloc_ready, 1);
    check("midrst_valid", alloc_valid, 0);
    check("midrst_bitmap", bitmap_out, 64'h0);
    check("midrst_count", free_count, 64);
    repeat (5) tick();

    check("alloc_queue_drained", aq.size(), 0);
    check("free_err_queue_drained", fq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             tests, fails);
    $finish;
  end

endmodule
